// File: rtl/vga_timing_pkg.sv
// Default 640x480 raster constants and helpers for the vga_timing block.
package vga_timing_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int H_TOTAL = SCREEN_W + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_H + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = SCREEN_W + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = SCREEN_H + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  function automatic int sync_start(input int active, input int front);
    return active + front;
  endfunction

  // Counter width that can also hold the total itself, so end-of-sync compares never overflow.
  function automatic int cnt_w(input int total);
    return (total < 1) ? 1 : $clog2(total + 1);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle: vga_timing drives the master side, pixel logic reads the slave side.
interface vga_timing_if
  import vga_timing_pkg::*;
#(
  parameter int w_x     = $clog2(SCREEN_W),
  parameter int w_y     = $clog2(SCREEN_H),
  parameter int w_frame = 8
);
  logic               pixel_en;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic [w_x-1:0]     x;
  logic [w_y-1:0]     y;
  logic               frame_start;
  logic [w_frame-1:0] frame_num;

  modport master (
    output pixel_en, hsync, vsync, display_on, x, y, frame_start, frame_num
  );
  modport slave (
    input  pixel_en, hsync, vsync, display_on, x, y, frame_start, frame_num
  );
endinterface

// File: rtl/vga_timing_clk_enable_divider.sv
// Divide-by-N clock enable: one registered strobe every N clks, first one N clks after reset.
module clk_enable_divider #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  output logic en_out
);
  localparam int CW = (N <= 1) ? 1 : $clog2(N);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;

  always_comb begin
    cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
    // Registered terminal count keeps the strobe glitch-free and low during reset, even for N=1.
    en_d  = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign en_out = en_q;
endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-rate enable, h/v counters, registered sync/active/coordinate outputs.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int clk_mhz       = 50,
  parameter int pixel_mhz     = 25,
  parameter int screen_width  = SCREEN_W,
  parameter int screen_height = SCREEN_H,
  parameter int h_front       = H_FRONT,
  parameter int h_sync        = H_SYNC,
  parameter int h_back        = H_BACK,
  parameter int v_front       = V_FRONT,
  parameter int v_sync        = V_SYNC,
  parameter int v_back        = V_BACK,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int w_frame       = 8
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vif
);
  localparam int N        = clk_mhz / pixel_mhz;
  localparam int H_TOT    = screen_width + h_front + h_sync + h_back;
  localparam int V_TOT    = screen_height + v_front + v_sync + v_back;
  localparam int HW       = cnt_w(H_TOT);
  localparam int VW       = cnt_w(V_TOT);
  localparam int HS_START = sync_start(screen_width, h_front);
  localparam int HS_END   = HS_START + h_sync;
  localparam int VS_START = sync_start(screen_height, v_front);
  localparam int VS_END   = VS_START + v_sync;

  logic          pixel_en;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          display_on_q, display_on_d;
  logic [w_x-1:0] x_q, x_d;
  logic [w_y-1:0] y_q, y_d;
  logic          frame_start_q, frame_start_d;
  logic          active, at_origin;

  clk_enable_divider #(.N(N)) u_div (
    .clk    (clk),
    .rst    (rst),
    .en_out (pixel_en)
  );

  assign active    = (h_q < HW'(screen_width)) && (v_q < VW'(screen_height));
  assign at_origin = (h_q == '0) && (v_q == '0);

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    display_on_d  = display_on_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (pixel_en) begin
      if (h_q == HW'(H_TOT - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
      // Outputs describe the pre-increment position, one pixel period behind the counters.
      display_on_d  = active;
      hsync_d       = !((h_q >= HW'(HS_START)) && (h_q < HW'(HS_END)));
      vsync_d       = !((v_q >= VW'(VS_START)) && (v_q < VW'(VS_END)));
      x_d           = active ? h_q[w_x-1:0] : '0;
      y_d           = active ? v_q[w_y-1:0] : '0;
      frame_start_d = at_origin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [w_frame-1:0] frame_num_q, frame_num_d;

  always_comb begin
    frame_num_d = frame_num_q;
    if (pixel_en && at_origin) frame_num_d = frame_num_q + w_frame'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) frame_num_q <= '0;
    else      frame_num_q <= frame_num_d;
  end

  assign vif.frame_num = frame_num_q;
`else
  assign vif.frame_num = {w_frame{1'b0}};
`endif

  assign vif.pixel_en    = pixel_en;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.display_on  = display_on_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 at N=2 and N=1, plus a reduced raster for whole-frame checks.
module tb_vga_timing;

  typedef struct packed {
    logic        pe;
    logic        hs;
    logic        vs;
    logic        don;
    logic        fs;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  fn;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.w_x(10), .w_y(9), .w_frame(8)) if_m ();
  vga_timing_if #(.w_x(10), .w_y(9), .w_frame(8)) if_1 ();
  vga_timing_if #(.w_x(4),  .w_y(3), .w_frame(2)) if_s ();

  vga_timing dut_m (.clk(clk), .rst(rst), .vif(if_m));

  vga_timing #(.clk_mhz(25), .pixel_mhz(25)) dut_1 (.clk(clk), .rst(rst), .vif(if_1));

  vga_timing #(
    .screen_width(16), .screen_height(8),
    .h_front(2), .h_sync(4), .h_back(2),
    .v_front(2), .v_sync(2), .v_back(3),
    .w_x(4), .w_y(3), .w_frame(2)
  ) dut_s (.clk(clk), .rst(rst), .vif(if_s));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   jp      = 0;
  obs_t q_m[$];
  obs_t q_1[$];
  obs_t q_s[$];

  // Closed-form view after j consecutive clk edges with rst high (j=0: in reset).
  function automatic obs_t model(input int j, input int n, input int sw, input int sh,
                                 input int hf, input int hsw, input int hb,
                                 input int vf, input int vsw, input int vb, input int wf);
    obs_t e;
    int ht, vt, k, h, v;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    ht   = sw + hf + hsw + hb;
    vt   = sh + vf + vsw + vb;
    e.pe = (j >= n) && (j % n == 0);
    if (j >= n + 1) begin
      k     = (j - n - 1) / n;
      h     = k % ht;
      v     = (k / ht) % vt;
      e.don = (h < sw) && (v < sh);
      e.hs  = !((h >= sw + hf) && (h < sw + hf + hsw));
      e.vs  = !((v >= sh + vf) && (v < sh + vf + vsw));
      e.x   = e.don ? 16'(h) : 16'd0;
      e.y   = e.don ? 16'(v) : 16'd0;
      e.fs  = ((j - n - 1) % n == 0) && (h == 0) && (v == 0);
`ifdef VGA_FRAME_COUNTER_EN
      e.fn  = 8'(((k / (ht * vt)) + 1) % (1 << wf));
`endif
    end
    return e;
  endfunction

  function automatic obs_t exp_m(input int j);
    return model(j, 2, 640, 480, 16, 96, 48, 10, 2, 33, 8);
  endfunction
  function automatic obs_t exp_1(input int j);
    return model(j, 1, 640, 480, 16, 96, 48, 10, 2, 33, 8);
  endfunction
  function automatic obs_t exp_s(input int j);
    return model(j, 2, 16, 8, 2, 4, 2, 2, 2, 3, 2);
  endfunction

  function automatic obs_t obs_m();
    return {if_m.pixel_en, if_m.hsync, if_m.vsync, if_m.display_on, if_m.frame_start,
            16'(if_m.x), 16'(if_m.y), 8'(if_m.frame_num)};
  endfunction
  function automatic obs_t obs_1();
    return {if_1.pixel_en, if_1.hsync, if_1.vsync, if_1.display_on, if_1.frame_start,
            16'(if_1.x), 16'(if_1.y), 8'(if_1.frame_num)};
  endfunction
  function automatic obs_t obs_s();
    return {if_s.pixel_en, if_s.hsync, if_s.vsync, if_s.display_on, if_s.frame_start,
            16'(if_s.x), 16'(if_s.y), 8'(if_s.frame_num)};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pe=%b hs=%b vs=%b don=%b fs=%b x=%0d y=%0d fn=%0d",
                     o.pe, o.hs, o.vs, o.don, o.fs, o.x, o.y, o.fn);
  endfunction

  // Scoreboard drain: one queued expectation per DUT per clk.
  always @(negedge clk) begin
    obs_t e, o;
    if (q_m.size() > 0) begin
      e = q_m.pop_front(); o = obs_m(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_main got %s expected %s", fmt(o), fmt(e)); end
    end
    if (q_1.size() > 0) begin
      e = q_1.pop_front(); o = obs_1(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_n1 got %s expected %s", fmt(o), fmt(e)); end
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front(); o = obs_s(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_small got %s expected %s", fmt(o), fmt(e)); end
    end
  end

  // Drive rst for a number of clks and queue what every DUT must show after each of them.
  task automatic run(input logic r, input int cycles);
    int jj;
    #1;
    rst = r;
    jj  = jp;
    for (int i = 0; i < cycles; i++) begin
      jj = r ? jj + 1 : 0;
      q_m.push_back(exp_m(jj));
      q_1.push_back(exp_1(jj));
      q_s.push_back(exp_s(jj));
    end
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      jp = r ? jp + 1 : 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    jp = jp + 1;
  endtask

  task automatic test_reset();
    run(1'b0, 5);
    n_tests++;
    if ({if_m.pixel_en, if_m.hsync, if_m.vsync, if_m.display_on, if_m.frame_start} !== 5'b01100
        || if_m.x !== 10'd0 || if_m.y !== 9'd0 || if_m.frame_num !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values got %s expected pe=0 hs=1 vs=1 don=0 fs=0 x=0 y=0 fn=0", fmt(obs_m()));
    end
    run(1'b1, 2);
    n_tests++;
    if (if_m.pixel_en !== 1'b1 || if_m.display_on !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pixel_en pe=%b don=%b, expected pe=1 don=0", if_m.pixel_en, if_m.display_on);
    end
    run(1'b1, 1);
    n_tests++;
    if (if_m.display_on !== 1'b1 || if_m.frame_start !== 1'b1 || if_m.x !== 10'd0 || if_m.y !== 9'd0) begin
      n_fail++;
      $display("FAIL first_pixel got %s expected don=1 fs=1 x=0 y=0", fmt(obs_m()));
    end
    run(1'b1, 1);
    n_tests++;
    if (if_m.frame_start !== 1'b0 || if_m.display_on !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_width fs=%b don=%b, expected fs=0 don=1", if_m.frame_start, if_m.display_on);
    end
  endtask

  task automatic test_horizontal();
    int b, low, per;
    run(1'b1, 3300);
    b = 0; while (if_m.hsync !== 1'b1 && b < 2000) begin tick(); b++; end
    b = 0; while (if_m.hsync !== 1'b0 && b < 2000) begin tick(); b++; end
    n_tests++;
    if (if_m.hsync !== 1'b0 || if_m.display_on !== 1'b0) begin
      n_fail++;
      $display("FAIL hsync_fall hsync=%b don=%b, expected 0 and 0", if_m.hsync, if_m.display_on);
    end
    low = 0; while (if_m.hsync === 1'b0 && low < 400) begin tick(); low++; end
    n_tests++;
    if (low !== 192) begin n_fail++; $display("FAIL hsync_width got %0d clks, expected 192", low); end
    b = 0; while (if_m.display_on !== 1'b0 && b < 2000) begin tick(); b++; end
    b = 0; while (if_m.display_on !== 1'b1 && b < 2000) begin tick(); b++; end
    n_tests++;
    if (if_m.x !== 10'd0) begin n_fail++; $display("FAIL line_start_x got %0d expected 0", if_m.x); end
    per = 0;
    while (if_m.display_on === 1'b1 && per < 4000) begin tick(); per++; end
    while (if_m.display_on !== 1'b1 && per < 4000) begin tick(); per++; end
    n_tests++;
    if (per !== 1600) begin n_fail++; $display("FAIL line_period_n2 got %0d clks, expected 1600", per); end
  endtask

  task automatic test_n1();
    int miss, b, per;
    miss = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (if_1.pixel_en !== 1'b1) miss++; end
    n_tests++;
    if (miss !== 0) begin n_fail++; $display("FAIL n1_pixel_en got %0d low cycles, expected 0", miss); end
    b = 0; while (if_1.display_on !== 1'b0 && b < 1000) begin tick(); b++; end
    b = 0; while (if_1.display_on !== 1'b1 && b < 1000) begin tick(); b++; end
    per = 0;
    while (if_1.display_on === 1'b1 && per < 2000) begin tick(); per++; end
    while (if_1.display_on !== 1'b1 && per < 2000) begin tick(); per++; end
    n_tests++;
    if (per !== 800) begin n_fail++; $display("FAIL line_period_n1 got %0d clks, expected 800", per); end
  endtask

  task automatic test_vertical();
    int b, per, vlow, bad;
    run(1'b0, 1);
    run(1'b1, 1500);
    b = 0; while (if_s.frame_start !== 1'b1 && b < 800) begin tick(); b++; end
    per = 0; vlow = 0; bad = 0;
    do begin
      tick(); per++;
      if (if_s.vsync === 1'b0) vlow++;
      if (if_s.display_on !== 1'b1 && (if_s.x !== 4'd0 || if_s.y !== 3'd0)) bad++;
    end while (if_s.frame_start !== 1'b1 && per < 1600);
    n_tests++;
    if (per !== 720) begin n_fail++; $display("FAIL frame_period got %0d clks, expected 720", per); end
    n_tests++;
    if (vlow !== 96) begin n_fail++; $display("FAIL vsync_width got %0d clks, expected 96", vlow); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL blank_coords got %0d nonzero, expected 0", bad); end
  endtask

  task automatic test_mid_frame_reset();
    run(1'b0, 1);
    run(1'b1, 263);
    n_tests++;
    if (if_s.x !== 4'd10 || if_s.y !== 3'd5 || if_s.display_on !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame_pos got %s expected don=1 x=10 y=5", fmt(obs_s()));
    end
    run(1'b0, 1);
    n_tests++;
    if ({if_s.hsync, if_s.vsync, if_s.display_on} !== 3'b110 ||
        {if_m.hsync, if_m.vsync, if_m.display_on} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_reset small %s main %s expected hs=1 vs=1 don=0", fmt(obs_s()), fmt(obs_m()));
    end
    run(1'b1, 3);
    n_tests++;
    if (if_s.frame_start !== 1'b1 || if_s.display_on !== 1'b1 || if_s.x !== 4'd0 || if_s.y !== 3'd0) begin
      n_fail++;
      $display("FAIL restart_origin got %s expected fs=1 don=1 x=0 y=0", fmt(obs_s()));
    end
  endtask

  task automatic test_frame_num();
    int b;
    int exp_fn[5];
`ifdef VGA_FRAME_COUNTER_EN
    exp_fn = '{1, 2, 3, 0, 1};
`else
    exp_fn = '{0, 0, 0, 0, 0};
`endif
    run(1'b0, 1);
    run(1'b1, 3);
    n_tests++;
`ifdef VGA_FRAME_COUNTER_EN
    if (if_m.frame_num !== 8'd1) begin n_fail++; $display("FAIL main_frame_num got %0d expected 1", if_m.frame_num); end
`else
    if (if_m.frame_num !== 8'd0) begin n_fail++; $display("FAIL main_frame_num got %0d expected 0", if_m.frame_num); end
`endif
    for (int i = 0; i < 5; i++) begin
      b = 0; while (if_s.frame_start !== 1'b1 && b < 800) begin tick(); b++; end
      n_tests++;
      if (if_s.frame_start !== 1'b1 || int'(if_s.frame_num) !== exp_fn[i]) begin
        n_fail++;
        $display("FAIL frame_num_%0d got fs=%b fn=%0d, expected fs=1 fn=%0d", i, if_s.frame_start, if_s.frame_num, exp_fn[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_n1();
    test_vertical();
    test_mid_frame_reset();
    test_frame_num();
    run(1'b1, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640x480 graphics labs. It derives a pixel-rate clock enable from the system clock and runs horizontal and vertical counters. It produces active-low hsync/vsync, display_on, and the current pixel coordinates x/y. Those coordinates feed the colour-generating logic in lab_top, which returns red/green/blue for the same pixel. The block sits between the board clock and the per-pixel colour logic.

## Interface
- clk_mhz, 50: system clock frequency; must be an integer multiple of pixel_mhz
- pixel_mhz, 25: pixel rate; divide ratio N = clk_mhz / pixel_mhz (N ≥ 1)
- screen_width, 640 / screen_height, 480: active area
- h_front 16, h_sync 96, h_back 48: horizontal porches and sync, in pixels
- v_front 10, v_sync 2, v_back 33: vertical porches and sync, in lines
- w_x, $clog2(screen_width) / w_y, $clog2(screen_height): coordinate widths
- w_frame, 8: frame counter width
- clk  in  1  system clock; everything is synchronous to its rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- pixel_en  out  1  one-clk strobe, once per pixel period
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  high while the current pixel is in the active area
- x  out  w_x  pixel column; 0 outside the active area
- y  out  w_y  pixel row; 0 outside the active area
- frame_start  out  1  one-clk pulse when outputs present pixel (0,0)
- frame_num  out  w_frame  frame counter (see Configuration)

## Operation
- Derived totals: H_TOTAL = 640+16+96+48 = 800; V_TOTAL = 480+10+33+2 = 525.
- Clock divider:
  - counts 0..N-1 and wraps;
  - pixel_en = 1 in the clk cycle where the divider equals N-1;
  - N=1 gives pixel_en constantly high after reset.
- Internal counters:
  - h counts 0..H_TOTAL-1, v counts 0..V_TOTAL-1;
  - each is wide enough for its total (v needs 10 bits; w_y=9 cannot hold 524).
- On each pixel_en edge:
  - h increments; at H_TOTAL-1, h wraps to 0 and v increments;
  - at (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Output registers, loaded on the same pixel_en edge from the pre-increment (h,v):
  - display_on = (h < 640) & (v < 480);
  - hsync = 0 iff 656 ≤ h < 752;
  - vsync = 0 iff 490 ≤ v < 492;
  - x = display_on ? h[w_x-1:0] : 0, and y likewise from v;
  - frame_start = 1 iff (h,v) = (0,0), cleared on the next clk.
- Outputs hold their values between pixel_en strobes; all outputs are mutually aligned.
- Reset (rst=0 at any clk edge, including mid-frame):
  - divider=0, h=0, v=0;
  - hsync=1, vsync=1, display_on=0, x=0, y=0, frame_start=0, pixel_en=0, frame_num=0.
- After rst rises, the first pixel_en falls in cycle N. Its edge presents (0,0): display_on=1, frame_start=1.

## Timing
- Latency: 1 pixel period from counter state to outputs.
- hsync low for 96 pixel periods, i.e. 96·N clks; it begins 656 pixels after the line's pixel 0.
- Line period: 800·N clks. Frame period: 420000·N clks.
- vsync low for exactly 2 lines (1600 pixels); its edges coincide with h=0 boundaries.
- frame_start width: 1 clk, regardless of N.

## Configuration
- VGA_FRAME_COUNTER_EN defined:
  - frame_num increments modulo 2^w_frame on the pixel_en edge presenting (0,0), i.e. the same edge that raises frame_start;
  - the first frame after reset reads 1.
- VGA_FRAME_COUNTER_EN undefined:
  - frame_num is tied to 0 and no counter register exists.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants: 640/480, porches, sync widths, H_TOTAL, V_TOTAL;
  - the derived sync start/end positions.
- Sub-module clk_enable_divider:
  - parameter N; ports clk, rst, en_out;
  - it generates pixel_en.

## Test plan
- Reset: hold rst=0 for 5 clks → all outputs at reset values. Release → pixel_en in cycle 2 (N=2), then display_on=1, x=0, y=0, frame_start=1 for 1 clk.
- Horizontal timing (N=2): hsync falls when x would be 656 (display_on=0), stays low 192 clks, rises. Next line's x=0 arrives 1600 clks after the previous one.
- Vertical timing: vsync low only on lines 490 and 491. Over 2 frames, each frame_start is 840000 clks apart. y never exceeds 479; y=0 whenever display_on=0.
- Mid-frame reset: assert rst=0 at (h=300, v=200) for 1 clk → hsync=1, vsync=1, display_on=0. Release → frame restarts at (0,0) with frame_start.
- N=1 (clk_mhz=25): pixel_en high every cycle after reset; line period 800 clks.
- With VGA_FRAME_COUNTER_EN and w_frame=2: frame_num reads 1, 2, 3, 0, 1 across successive frame_starts. Without the macro, frame_num stays 0.
